// File: rtl/i2s_apb_regbank.sv
// i2s_apb_regbank: APB3 register bank for the I2S transceiver, with wait states, PSLVERR and per-channel FIFO holding registers
module i2s_apb_regbank #(
    parameter int NUM_CH  = 2,
    parameter int DATA_W  = 32,
    parameter int CTRL_W  = 28,
    parameter int TIMEOUT = 15
) (
    input  logic                     pclk,
    input  logic                     preset,
    input  logic                     psel,
    input  logic                     penable,
    input  logic                     pwrite,
    input  logic [7:0]               paddr,
    input  logic [31:0]              pwdata,
    output logic [31:0]              prdata,
    output logic                     pready,
    output logic                     pslverr,
    input  logic [3:0]               flags,
    output logic [CTRL_W-1:0]        controls,
    input  logic [NUM_CH-1:0]        tx_full,
    output logic [NUM_CH-1:0]        tx_wen,
    output logic [NUM_CH*DATA_W-1:0] tx_data,
    input  logic [NUM_CH-1:0]        rx_empty,
    output logic [NUM_CH-1:0]        rx_ren,
    input  logic [NUM_CH*DATA_W-1:0] rx_rdata,
    output logic                     irq
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t state, state_n;
    logic [7:0] wcnt;
    logic [5:0] idx;
    logic [NUM_CH-1:0] sel_tx, sel_rx, tx_pend, tx_wt, rx_valid, rx_rd, rx_cap;
    logic [NUM_CH*DATA_W-1:0] rx_buf;
    logic [DATA_W-1:0] rx_sel;
    logic [2*NUM_CH-1:0] irq_en, irq_stat;
    logic [31:0] rdata;
    logic mapped, err, stall, tout, finish, wr, rd, unused;

    assign unused = ^paddr[1:0];
    assign idx = paddr[7:2];

    always_comb begin
        sel_tx = '0;
        sel_rx = '0;
        rx_sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            sel_tx[c] = idx[5:1] == 5'(2 + c) && !idx[0];
            sel_rx[c] = idx[5:1] == 5'(2 + c) && idx[0];
            rx_sel |= sel_rx[c] ? rx_buf[c*DATA_W +: DATA_W] : '0;
        end
    end

    // Decode happens on the setup-phase edge so an unstalled access answers in the first access cycle
    assign mapped = idx < 6'd4 || |sel_tx || |sel_rx;
    assign err    = !mapped || (pwrite && (idx == 6'd1 || |sel_rx)) || (!pwrite && |sel_tx);
    assign stall  = !err && (pwrite ? |(sel_tx & tx_pend) : |(sel_rx & ~rx_valid));
    assign tout   = state == WAIT && stall && wcnt == 8'(TIMEOUT);
    assign finish = (state == IDLE && psel && !penable && !stall) || (state == WAIT && psel && (!stall || tout));
    assign wr     = finish && !err && !stall && pwrite;
    assign rd     = finish && !err && !stall && !pwrite;
    assign tx_wt  = wr ? sel_tx : '0;
    assign rx_rd  = rd ? sel_rx : '0;

    always_comb begin
        rdata   = idx == 6'd0 ? 32'(controls) :
                  idx == 6'd1 ? 32'({rx_valid, tx_pend, flags}) :
                  idx == 6'd2 ? 32'(irq_en) :
                  idx == 6'd3 ? 32'(irq_stat) : 32'(rx_sel);
        state_n = state == IDLE ? (psel && !penable ? (stall ? WAIT : DONE) : IDLE) :
                  state == WAIT ? (!psel ? IDLE : finish ? DONE : WAIT) : IDLE;
    end

    always_ff @(posedge pclk or negedge preset)
        if (!preset) begin
            state    <= IDLE;
            wcnt     <= '0;
            pready   <= 1'b0;
            pslverr  <= 1'b0;
            prdata   <= '0;
            controls <= '0;
            irq_en   <= '0;
            irq_stat <= '0;
            tx_pend  <= '0;
            tx_wen   <= '0;
            tx_data  <= '0;
            rx_valid <= '0;
            rx_ren   <= '0;
            rx_cap   <= '0;
            rx_buf   <= '0;
            irq      <= 1'b0;
        end else begin
            state    <= state_n;
            wcnt     <= state_n == WAIT ? (state == WAIT ? wcnt + 8'd1 : 8'd1) : 8'd0;
            pready   <= finish;
            pslverr  <= finish && (err || stall);
            prdata   <= rd ? rdata : '0;
            if (wr && idx == 6'd0) controls <= pwdata[CTRL_W-1:0];
            if (wr && idx == 6'd2) irq_en <= pwdata[2*NUM_CH-1:0];
            irq_stat <= (irq_stat & ~(wr && idx == 6'd3 ? pwdata[2*NUM_CH-1:0] : '0)) | {rx_cap, tx_pend & ~tx_full & ~tx_wt};
            tx_pend  <= tx_wt | (tx_pend & tx_full);
            tx_wen   <= tx_pend & ~tx_full;
            // rx_rdata is valid the cycle after rx_ren, so capture one cycle later via rx_cap
            rx_valid <= (rx_valid & ~rx_rd) | rx_cap;
            rx_ren   <= (~rx_valid | rx_rd) & ~rx_empty & ~rx_ren & ~rx_cap;
            rx_cap   <= rx_ren;
            irq      <= |(irq_stat & irq_en);
            for (int c = 0; c < NUM_CH; c++) begin
                if (tx_wt[c]) tx_data[c*DATA_W +: DATA_W] <= pwdata[DATA_W-1:0];
                if (rx_cap[c]) rx_buf[c*DATA_W +: DATA_W] <= rx_rdata[c*DATA_W +: DATA_W];
            end
        end
endmodule
